rgb_breath_pwm: RTL and testbench
=================================

// Module: rgb_breath_pwm
// PURPOSE
//  Consumes the three 8-bit per-colour duty targets from the colour decoder (R/G/B_time).
//  Drives the three RGB LED pins with 256-step PWM, scaled by a triangular "breathing" envelope.
//  Duty targets are captured only at PWM frame boundaries, so LED pulses are never torn.
//  Sits between the switch-driven colour decoder and the board LED pins.
// PARAMETERS
//  CLK_DIV      4  clocks per PWM count (>=1); frame = 256*CLK_DIV clocks
//  STEP         1  envelope increment/decrement per step (1..255)
//  FRAMES_STEP  2  PWM frames per envelope step (>=1)
//  HOLD_STEPS   8  envelope steps held at peak and at trough (>=0)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset, asynchronous, active-high
//  en           in   1  breathing enable; low forces idle
//  R_time_in    in   8  red duty target (0=off, 255=max)
//  G_time_in    in   8  green duty target
//  B_time_in    in   8  blue duty target
//  led_r        out  1  red PWM output
//  led_g        out  1  green PWM output
//  led_b        out  1  blue PWM output
//  frame_start  out  1  one-cycle pulse; coincides with the first cycle of pwm_cnt==0
//  env_level    out  8  current envelope value
// BEHAVIOUR
//  Reset and idle values:
//  - rst (async) clears: prescaler, pwm_cnt, frame/hold counters, env, duty regs, state=IDLE.
//  - While rst is asserted, all outputs are 0.
//  Counting:
//  - tick = (prescaler==CLK_DIV-1); the prescaler wraps to 0 on tick.
//  - pwm_cnt increments on tick and wraps 255->0.
//  - fb (frame boundary) = tick && pwm_cnt==255.
//  Frame boundary (fb):
//  - Load duty_x <= (x_time_in * (env+1)) >> 8, using a 16-bit product and the pre-update env.
//  - Result range: env=255 gives duty=time_in; env=0 gives duty=0.
//  - frame_start <= 1 on the next cycle.
//  - Inputs are ignored between boundaries.
//  Outputs:
//  - led_x = registered (duty_x > pwm_cnt): high for exactly duty_x counts per frame.
//  - duty 0 never lights; duty 255 lights 255 of 256 counts.
//  Envelope FSM (advances only on steps; step = fb && frame_cnt==FRAMES_STEP-1):
//  - IDLE:   env=0. Goes to RISE on the first clock with en=1. Counters start from 0.
//  - RISE:   if env >= 255-STEP then env=255, go to PEAK; else env += STEP.
//  - PEAK:   hold HOLD_STEPS steps, then FALL (HOLD_STEPS=0 -> FALL on the next step).
//  - FALL:   if env <= STEP then env=0, go to TROUGH; else env -= STEP.
//  - TROUGH: hold HOLD_STEPS steps, then RISE.
//  - Arithmetic saturates; env never wraps.
//  en deassert (any state, mid-frame):
//  - Synchronous clear of prescaler, pwm_cnt, counters, env and duty regs; state=IDLE.
//  - led_x=0 from the next cycle.
//  - frame_start is not pulsed.
//  Simultaneous events:
//  - rst overrides everything.
//  - en=0 overrides fb.
//  - If fb and a step coincide, the duty load uses the pre-update env.
//  Latency:
//  - An input change becomes visible at the first frame_start after it; worst case 256*CLK_DIV+1 clocks.
// STRUCTURE
//  Package breath_pkg:
//  - state enum {IDLE, RISE, PEAK, FALL, TROUGH}
//  - PWM_W=8, ENV_W=8, PROD_W=16
//  Sub-module rgb_pwm_channel, instantiated x3:
//  - duty register with fb-gated load (scaling multiply included) and compare against shared pwm_cnt.
//  Top level holds: prescaler, pwm_cnt, frame/hold counters, envelope FSM.
// TESTING (CLK_DIV=1, STEP=64, FRAMES_STEP=1, HOLD_STEPS=1 unless noted)
//  1. Envelope sequence
//     en=1, all inputs 0xFF -> env per frame: 0,64,128,192,255(PEAK),255,191,127,63,0(TROUGH),0,64...
//  2. Scaling at full envelope
//     At env=255: R=0x7F, G=0x1F, B=0xFF -> per-frame high counts 127, 31, 255.
//  3. Mid-frame input change
//     Change R_time_in at pwm_cnt=100 -> led_r pattern unchanged until the next frame_start, then uses the new duty.
//  4. Disable mid-frame
//     en 1->0 at pwm_cnt=37 -> the next cycle all led_x=0, env_level=0, no frame_start.
//     Re-enable -> env restarts at 0 in RISE.
//  5. Reset mid-frame
//     rst pulsed async mid-frame (between clock edges) -> outputs 0 immediately; after release with en=1, the sequence restarts as in test 1.
//  6. Corner values
//     Inputs 0x00 -> led_x never high.
//     CLK_DIV=3 -> frame_start period is 768 clocks.
//     HOLD_STEPS=0 -> PEAK lasts exactly one step.

Source files
------------

// File: rtl/breath_pkg.sv
// breath_pkg: shared widths, envelope states and duty scaling for the RGB breathing PWM.
package breath_pkg;
    localparam int PWM_W  = 8;
    localparam int ENV_W  = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {IDLE, RISE, PEAK, FALL, TROUGH} state_t;

    // (time * (env+1)) >> 8 so that env=255 passes time through and env=0 gives 0
    function automatic logic [PWM_W-1:0] scale(input logic [PWM_W-1:0] t, input logic [ENV_W-1:0] e);
        logic [PROD_W-1:0] p;
        p = PROD_W'(t) * (PROD_W'(e) + PROD_W'(1));
        return p[PROD_W-1 -: PWM_W];
    endfunction
endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: one colour channel; duty captured only at frame boundaries, compared to the shared counter.
module rgb_pwm_channel
    import breath_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             fb,
    input  logic [PWM_W-1:0] time_in,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [ENV_W-1:0] env,
    output logic             led
);
    logic [PWM_W-1:0] duty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty <= '0;
            led  <= 1'b0;
        end else if (clr) begin
            duty <= '0;
            led  <= 1'b0;
        end else begin
            duty <= fb ? scale(time_in, env) : duty;
            led  <= duty > pwm_cnt;
        end
    end
endmodule

// File: rtl/rgb_breath_pwm.sv
// rgb_breath_pwm: three-channel 256-step PWM scaled by a triangular breathing envelope.
// Holds the prescaler, PWM counter, frame/hold counters and the envelope FSM.
module rgb_breath_pwm
    import breath_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int STEP        = 1,
    parameter int FRAMES_STEP = 2,
    parameter int HOLD_STEPS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] R_time_in,
    input  logic [PWM_W-1:0] G_time_in,
    input  logic [PWM_W-1:0] B_time_in,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             frame_start,
    output logic [ENV_W-1:0] env_level
);
    localparam int CNT_W     = 16;
    localparam int HOLD_LAST = HOLD_STEPS > 0 ? HOLD_STEPS - 1 : 0;

    logic [CNT_W-1:0] prescaler, frame_cnt, hold_cnt, hold_n;
    logic [PWM_W-1:0] pwm_cnt;
    logic [ENV_W-1:0] env, env_n;
    state_t           state, state_n;
    logic             tick, fb, step;

    assign tick      = prescaler == CNT_W'(CLK_DIV - 1);
    assign fb        = tick && pwm_cnt == '1;
    assign step      = fb && frame_cnt == CNT_W'(FRAMES_STEP - 1);
    assign env_level = env;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            env         <= '0;
            state       <= IDLE;
            frame_start <= 1'b0;
        end else if (!en) begin
            prescaler   <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            env         <= '0;
            state       <= IDLE;
            frame_start <= 1'b0;
        end else begin
            prescaler   <= tick ? '0 : prescaler + CNT_W'(1);
            pwm_cnt     <= tick ? pwm_cnt + PWM_W'(1) : pwm_cnt;
            frame_cnt   <= step ? '0 : fb ? frame_cnt + CNT_W'(1) : frame_cnt;
            hold_cnt    <= hold_n;
            env         <= env_n;
            state       <= state_n;
            frame_start <= fb;
        end
    end

    // Saturating envelope: clamps to 255/0 instead of wrapping
    always_comb begin
        state_n = state;
        env_n   = env;
        hold_n  = hold_cnt;
        case (state)
            IDLE: state_n = RISE;
            RISE: if (step) begin
                if (env >= ENV_W'(255 - STEP)) begin
                    env_n   = '1;
                    state_n = PEAK;
                    hold_n  = '0;
                end else env_n = env + ENV_W'(STEP);
            end
            PEAK: if (step) begin
                if (hold_cnt == CNT_W'(HOLD_LAST)) begin
                    state_n = FALL;
                    hold_n  = '0;
                end else hold_n = hold_cnt + CNT_W'(1);
            end
            FALL: if (step) begin
                if (env <= ENV_W'(STEP)) begin
                    env_n   = '0;
                    state_n = TROUGH;
                    hold_n  = '0;
                end else env_n = env - ENV_W'(STEP);
            end
            TROUGH: if (step) begin
                if (hold_cnt == CNT_W'(HOLD_LAST)) begin
                    state_n = RISE;
                    hold_n  = '0;
                end else hold_n = hold_cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    rgb_pwm_channel u_r (.clk(clk), .rst(rst), .clr(!en), .fb(fb), .time_in(R_time_in), .pwm_cnt(pwm_cnt), .env(env), .led(led_r));
    rgb_pwm_channel u_g (.clk(clk), .rst(rst), .clr(!en), .fb(fb), .time_in(G_time_in), .pwm_cnt(pwm_cnt), .env(env), .led(led_g));
    rgb_pwm_channel u_b (.clk(clk), .rst(rst), .clr(!en), .fb(fb), .time_in(B_time_in), .pwm_cnt(pwm_cnt), .env(env), .led(led_b));
endmodule

// File: tb/tb_rgb_breath_pwm.sv
// tb_rgb_breath_pwm: randomized bench for rgb_breath_pwm against a frame-level envelope/duty model.
module tb_rgb_breath_pwm;
    localparam int CD[4]  = '{1, 3, 1, 2};
    localparam int STP[4] = '{64, 64, 64, 100};
    localparam int FPS[4] = '{1, 1, 1, 2};
    localparam int HLD[4] = '{1, 1, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic [3:0] lr, lg, lb, fs;
    logic [7:0] ev [4];
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    rgb_breath_pwm #(.CLK_DIV(1), .STEP(64), .FRAMES_STEP(1), .HOLD_STEPS(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
        .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]), .frame_start(fs[0]), .env_level(ev[0]));
    rgb_breath_pwm #(.CLK_DIV(3), .STEP(64), .FRAMES_STEP(1), .HOLD_STEPS(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
        .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]), .frame_start(fs[1]), .env_level(ev[1]));
    rgb_breath_pwm #(.CLK_DIV(1), .STEP(64), .FRAMES_STEP(1), .HOLD_STEPS(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
        .led_r(lr[2]), .led_g(lg[2]), .led_b(lb[2]), .frame_start(fs[2]), .env_level(ev[2]));
    rgb_breath_pwm #(.CLK_DIV(2), .STEP(100), .FRAMES_STEP(2), .HOLD_STEPS(3)) u3 (
        .clk(clk), .rst(rst), .en(en), .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
        .led_r(lr[3]), .led_g(lg[3]), .led_b(lb[3]), .frame_start(fs[3]), .env_level(ev[3]));

    // Envelope for frame k after enable: one breathing period built with saturating arithmetic
    function automatic int exp_env(int d, int k);
        int q[$];
        int v;
        v = 0;
        while (v < 255) begin q.push_back(v); v = (v + STP[d] > 255) ? 255 : v + STP[d]; end
        repeat ((HLD[d] > 0) ? HLD[d] : 1) q.push_back(255);
        v = 255;
        while (v > 0) begin q.push_back(v); v = (v - STP[d] < 0) ? 0 : v - STP[d]; end
        repeat ((HLD[d] > 0) ? HLD[d] : 1) q.push_back(0);
        return q[(k / FPS[d]) % q.size()];
    endfunction

    task automatic do_reset();
        en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_fs(int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 512 * CD[d] + 8; i++) begin
            if (fs[d]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // chg: -2 inputs held, -1 new random inputs at a random point each frame, >=0 at that offset
    task automatic run_frames(int d, int n, int chg);
        bit ok;
        int cr, cg, cb, cf, er, eg, eb, ee, pe, len, at;
        wait_fs(d, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL first_frame_start d=%0d: got no pulse within bound, expected a pulse", d);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            ee  = exp_env(d, k);
            pe  = exp_env(d, k - 1);
            er  = (int'(r_in) * (pe + 1)) >> 8;
            eg  = (int'(g_in) * (pe + 1)) >> 8;
            eb  = (int'(b_in) * (pe + 1)) >> 8;
            len = 256 * CD[d];
            at  = (chg == -1) ? int'($urandom_range(1, len - 1)) : chg;
            checks++;
            if (ev[d] !== 8'(ee)) begin
                failures++;
                $display("FAIL env d=%0d frame=%0d: got %0d expected %0d", d, k, ev[d], ee);
            end
            cr = 0; cg = 0; cb = 0; cf = 0;
            for (int i = 0; i < len; i++) begin
                cr += int'(lr[d]); cg += int'(lg[d]); cb += int'(lb[d]); cf += int'(fs[d]);
                if (i == at) begin r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom); end
                @(negedge clk);
            end
            checks += 5;
            if (cr != CD[d] * er) begin failures++; $display("FAIL red_count d=%0d frame=%0d: got %0d expected %0d", d, k, cr, CD[d] * er); end
            if (cg != CD[d] * eg) begin failures++; $display("FAIL green_count d=%0d frame=%0d: got %0d expected %0d", d, k, cg, CD[d] * eg); end
            if (cb != CD[d] * eb) begin failures++; $display("FAIL blue_count d=%0d frame=%0d: got %0d expected %0d", d, k, cb, CD[d] * eb); end
            if (cf != 1) begin failures++; $display("FAIL frame_start_count d=%0d frame=%0d: got %0d expected 1", d, k, cf); end
            if (fs[d] !== 1'b1) begin failures++; $display("FAIL frame_period d=%0d frame=%0d: got %b at %0d clocks expected 1", d, k, fs[d], len); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
        repeat (4) @(negedge clk);
        checks += 2;
        if ({lr, lg, lb, fs} !== 16'h0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", {lr, lg, lb, fs}); end
        if (ev[0] !== 8'h0) begin failures++; $display("FAIL reset_env: got %0d expected 0", ev[0]); end
    endtask

    task automatic test_envelope();
        do_reset();
        r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
        en = 1'b1;
        run_frames(0, 12, -2);
    endtask

    task automatic test_scaling();
        do_reset();
        r_in = 8'h7F; g_in = 8'h1F; b_in = 8'hFF;
        en = 1'b1;
        run_frames(0, 6, -2);
    endtask

    task automatic test_midframe();
        do_reset();
        r_in = 8'hFF; g_in = 8'h40; b_in = 8'h80;
        en = 1'b1;
        run_frames(0, 8, 100);
    endtask

    task automatic test_random();
        do_reset();
        r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        en = 1'b1;
        run_frames(0, 12, -1);
    endtask

    task automatic test_zero();
        do_reset();
        r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
        en = 1'b1;
        run_frames(0, 8, -2);
    endtask

    task automatic test_disable();
        int cf, cl;
        do_reset();
        r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
        en = 1'b1;
        run_frames(0, 5, -2);
        repeat (37) @(negedge clk);
        checks++;
        if (lr[0] !== 1'b1) begin failures++; $display("FAIL led_before_disable: got %b expected 1", lr[0]); end
        en = 1'b0;
        @(negedge clk);
        checks += 3;
        if ({lr[0], lg[0], lb[0]} !== 3'b000) begin failures++; $display("FAIL disable_leds: got %b expected 000", {lr[0], lg[0], lb[0]}); end
        if (ev[0] !== 8'h0) begin failures++; $display("FAIL disable_env: got %0d expected 0", ev[0]); end
        if (fs[0] !== 1'b0) begin failures++; $display("FAIL disable_frame_start: got %b expected 0", fs[0]); end
        cf = 0; cl = 0;
        for (int i = 0; i < 300; i++) begin
            cf += int'(fs[0]);
            cl += int'(lr[0]) + int'(lg[0]) + int'(lb[0]);
            @(negedge clk);
        end
        checks += 2;
        if (cf != 0) begin failures++; $display("FAIL idle_frame_start: got %0d pulses expected 0", cf); end
        if (cl != 0) begin failures++; $display("FAIL idle_leds: got %0d lit samples expected 0", cl); end
        en = 1'b1;
        run_frames(0, 6, -2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
        en = 1'b1;
        run_frames(0, 5, -2);
        repeat (50) @(negedge clk);
        checks++;
        if (lr[0] !== 1'b1) begin failures++; $display("FAIL led_before_reset: got %b expected 1", lr[0]); end
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if ({lr[0], lg[0], lb[0], fs[0]} !== 4'b0) begin failures++; $display("FAIL async_reset_outputs: got %b expected 0000", {lr[0], lg[0], lb[0], fs[0]}); end
        if (ev[0] !== 8'h0) begin failures++; $display("FAIL async_reset_env: got %0d expected 0", ev[0]); end
        @(negedge clk);
        rst = 1'b0;
        run_frames(0, 12, -2);
    endtask

    task automatic test_corners();
        do_reset();
        r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        en = 1'b1;
        run_frames(1, 3, -1);
        do_reset();
        r_in = 8'hFF; g_in = 8'h80; b_in = 8'h01;
        en = 1'b1;
        run_frames(2, 14, -2);
        do_reset();
        r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        en = 1'b1;
        run_frames(3, 26, -1);
    endtask

    initial begin
        test_reset();
        test_envelope();
        test_scaling();
        test_midframe();
        test_random();
        test_zero();
        test_disable();
        test_reset_mid();
        test_corners();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
